// File: rtl/id_mapper_pool.sv
// Binds inner transaction IDs to a pool of outer IDs, counting in-flight
// transactions per binding and translating responses back to the inner ID.
module id_mapper_pool #(
  parameter int IN_ID_BITS  = 2,
  parameter int OUT_ID_BITS = 5,
  parameter int SLOTS       = 4,
  parameter int CNT_BITS    = 3,
  parameter int OUT_ID_BASE = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         io_req_valid,
  output logic                         io_req_ready,
  input  logic [IN_ID_BITS-1:0]        io_req_in_id,
  output logic [OUT_ID_BITS-1:0]       io_req_out_id,
  input  logic                         io_resp_valid,
  input  logic [OUT_ID_BITS-1:0]       io_resp_out_id,
  output logic                         io_resp_matches,
  output logic [IN_ID_BITS-1:0]        io_resp_in_id,
  output logic                         io_busy,
  output logic [$clog2(SLOTS+1)-1:0]   io_free_slots
);

  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int FREE_W = $clog2(SLOTS + 1);
  localparam logic [CNT_BITS-1:0] MAXC = '1;

  logic [SLOTS-1:0]      r_valid;
  logic [IN_ID_BITS-1:0] r_tag [SLOTS];
  logic [CNT_BITS-1:0]   r_cnt [SLOTS];

  logic [SLOTS-1:0]      w_hit_vec;
  logic [SLOTS-1:0]      w_alloc_vec;
  logic [SLOTS-1:0]      w_resp_sel;
  logic                  w_hit;
  logic                  w_any_free;
  logic                  w_hit_full;
  logic                  w_fire;
  logic [IDX_W-1:0]      w_hit_idx;
  logic [IDX_W-1:0]      w_free_idx;
  logic [IN_ID_BITS-1:0] w_resp_tag;
  logic [FREE_W-1:0]     w_free_cnt;

  // Lowest invalid slot as a one-hot vector: x & -x with x = ~r_valid.
  assign w_alloc_vec = ~r_valid & (r_valid + SLOTS'(1));
  assign w_hit       = |w_hit_vec;
  assign w_any_free  = ~&r_valid;
  assign w_fire      = io_req_valid & io_req_ready;

  always_comb begin
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_hit_full = 1'b0;
    w_resp_tag = '0;
    w_free_cnt = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (w_hit_vec[k]) w_hit_idx = IDX_W'(k);
      if (!r_valid[k])  w_free_idx = IDX_W'(k);
    end
    for (int k = 0; k < SLOTS; k++) begin
      if (w_hit_vec[k] && (r_cnt[k] == MAXC)) w_hit_full = 1'b1;
      if (w_resp_sel[k]) w_resp_tag = w_resp_tag | r_tag[k];
      if (!r_valid[k])   w_free_cnt = w_free_cnt + FREE_W'(1);
    end
  end

  // Ready deliberately ignores any same-cycle retire.
  assign io_req_ready    = w_hit ? !w_hit_full : w_any_free;
  assign io_req_out_id   = OUT_ID_BITS'(OUT_ID_BASE) +
                           OUT_ID_BITS'(w_hit ? w_hit_idx : w_free_idx);
  assign io_resp_matches = |w_resp_sel;
  assign io_resp_in_id   = w_resp_tag;
  assign io_busy         = |r_valid;
  assign io_free_slots   = w_free_cnt;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    logic w_alloc;
    logic w_inc;
    logic w_dec;

    assign w_hit_vec[gi]  = r_valid[gi] && (r_tag[gi] == io_req_in_id);
    assign w_resp_sel[gi] = r_valid[gi] &&
                            (io_resp_out_id == OUT_ID_BITS'(OUT_ID_BASE + gi));
    assign w_alloc = w_fire && !w_hit && w_alloc_vec[gi];
    assign w_inc   = w_fire && w_hit && w_hit_vec[gi];
    assign w_dec   = io_resp_valid && w_resp_sel[gi];

    // An allocated slot was invalid, so it can never be retiring in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid[gi] <= 1'b0;
        r_tag[gi]   <= '0;
        r_cnt[gi]   <= '0;
      end else if (w_alloc) begin
        r_valid[gi] <= 1'b1;
        r_tag[gi]   <= io_req_in_id;
        r_cnt[gi]   <= CNT_BITS'(1);
      end else if (w_inc && !w_dec) begin
        r_cnt[gi]   <= r_cnt[gi] + CNT_BITS'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt[gi]   <= r_cnt[gi] - CNT_BITS'(1);
        if (r_cnt[gi] == CNT_BITS'(1)) r_valid[gi] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/id_mapper_pool.md
# id_mapper_pool

Outstanding-transaction ID mapper for the AXI4/TileLink bridge path of the RISC-V core subsystem. It binds each upstream (inner) transaction ID to one of a pool of downstream (outer) IDs and counts in-flight transactions per binding. Responses are translated back to the inner ID. A binding is released when its last outstanding response retires. Same-ID request ordering is preserved because every concurrent transaction for an inner ID uses the same outer ID.

## Interface

Parameters:
- IN_ID_BITS, 2, inner ID width.
- OUT_ID_BITS, 5, outer ID width.
- SLOTS, 4, number of outer IDs in the pool. Must satisfy OUT_ID_BASE + SLOTS <= 2^OUT_ID_BITS.
- CNT_BITS, 3, per-slot outstanding counter width. Maximum outstanding per slot MAXC = 2^CNT_BITS - 1.
- OUT_ID_BASE, 0, outer ID assigned to slot 0. Slot k maps to outer ID OUT_ID_BASE + k.

Ports:
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high; clears all slots.
- io_req_valid, in, 1, new request offered.
- io_req_ready, out, 1, request can be accepted this cycle.
- io_req_in_id, in, IN_ID_BITS, inner ID of the request.
- io_req_out_id, out, OUT_ID_BITS, outer ID granted; meaningful only when ready is high.
- io_resp_valid, in, 1, one response completes this cycle.
- io_resp_out_id, in, OUT_ID_BITS, outer ID of the response.
- io_resp_matches, out, 1, resp_out_id names a live slot.
- io_resp_in_id, out, IN_ID_BITS, inner ID of the matched slot; 0 when there is no match.
- io_busy, out, 1, at least one slot is valid.
- io_free_slots, out, clog2(SLOTS+1), count of invalid slots.

## Operation

- State per slot k: valid, tag (IN_ID_BITS), cnt (CNT_BITS). All state is in registers.
- Hit: a valid slot whose tag equals io_req_in_id. At most one hit can exist.
- io_req_ready is combinational from registered state only, with no bypass from a same-cycle response:
  - On a hit, ready = (cnt < MAXC).
  - With no hit, ready = (any slot invalid).
- io_req_out_id = OUT_ID_BASE + hit index. With no hit, it is OUT_ID_BASE + lowest-index invalid slot. If no slot is free, it is OUT_ID_BASE.
- Request fire = io_req_valid & io_req_ready.
  - On a hit, cnt increments.
  - Otherwise the lowest free slot is set to valid=1, tag=in_id, cnt=1.
- Response match:
  - io_resp_matches = resp_out_id is in [OUT_ID_BASE, OUT_ID_BASE+SLOTS) and that slot is valid.
  - It is combinational and independent of io_resp_valid.
- Response retire = io_resp_valid & io_resp_matches: the slot's cnt decrements. If cnt goes 1->0, valid clears.
- A response with io_resp_valid high and no match is ignored. No state changes.
- Simultaneous fire and retire on the same slot:
  - cnt is unchanged and the slot stays valid, including the cnt==1 case.
- A slot freed by a retire is not allocatable until the next cycle.
- cnt never wraps: ready blocks at MAXC, and a retire only occurs when cnt >= 1.

## Timing

- Reset values:
  - All slots valid=0, cnt=0, tag=0.
  - io_req_ready=1, io_req_out_id=OUT_ID_BASE.
  - io_resp_matches=0, io_resp_in_id=0.
  - io_busy=0, io_free_slots=SLOTS.
- Reset asserted mid-operation discards every binding immediately. Outstanding responses arriving after reset do not match.
- Request path has zero latency: out_id and ready are valid in the same cycle as valid and in_id. Bookkeeping updates on the clk edge at fire.
- Response path has zero latency: matches and in_id are combinational in the same cycle. The counter update takes effect on the next edge.
- io_busy and io_free_slots reflect registered state, so they lag fire and retire by one cycle.

## Test plan

- Reset then single request in_id=2:
  - Before the edge: out_id=0, ready=1.
  - After the edge: free_slots=3, busy=1.
  - Response out_id=0 gives matches=1, in_id=2. After the retire: free_slots=4, busy=0.
- Same-ID stacking, in_id=1:
  - Requests 1..7 are all accepted, each with out_id=0. Request 8 sees ready=0.
  - One response out_id=0 retires. The next cycle, ready=1 again.
- Pool exhaustion:
  - in_ids 0,1,2,3 receive out_ids 0,1,2,3. A fifth distinct in_id cannot exist at 2 bits, so rerun with IN_ID_BITS=3.
  - in_id=4 sees ready=0 until one slot fully retires, then gets that slot's out_id.
- Simultaneous fire and retire on slot 0 (cnt=1, tag=1):
  - Request in_id=1 and response out_id=0 in the same cycle.
  - Afterwards slot 0 has valid=1, cnt=1, and free_slots is unchanged.
- Unmatched response:
  - io_resp_valid with out_id=9 (outside the pool), or with out_id=3 while slot 3 is invalid.
  - Required: matches=0, in_id=0, no state change.
- Async reset asserted between edges with 3 slots live:
  - Outputs return to their reset values before the next clk edge.
  - A later response out_id=1 gives matches=0.
